// File: rtl/fifo_rd_framer.sv
// fifo_rd_framer: pops bytes from a non-show-ahead FIFO and frames them into
// packets of HDR_BYTE, PKT_LEN payload bytes and an 8-bit modular checksum,
// presented on a valid/ready byte stream.
//
// Ports
//   clk_rd         single clock (FIFO read side)
//   rst_rd_n       asynchronous active-low reset
//   fifo_empty_rd  upstream FIFO empty flag
//   rd_en          pop strobe to upstream FIFO; rd_data is valid the next cycle
//   rd_data        upstream FIFO data
//   m_data         stream byte out
//   m_valid        m_data is valid
//   m_ready        downstream accepts the byte when m_valid is high
//   m_last         marks the checksum byte (final byte of a packet)
//   pkt_cnt        completed packet count, wraps at 16 bits
//
// State table
//   state      | meaning
//   ST_IDLE    | waiting for FIFO data to start a packet
//   ST_HDR     | presenting the header byte
//   ST_PAYLOAD | fetching from FIFO and streaming PKT_LEN payload bytes
//   ST_CSUM    | presenting the checksum byte (m_last=1)

module fifo_rd_framer #(
    parameter int unsigned PKT_LEN  = 16,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic        clk_rd,
    input  logic        rst_rd_n,
    input  logic        fifo_empty_rd,
    output logic        rd_en,
    input  logic [7:0]  rd_data,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic [15:0] pkt_cnt
);

    localparam logic [7:0] LEN    = 8'(PKT_LEN);
    localparam logic [7:0] LEN_M1 = 8'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CSUM    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  buf0_q, buf0_d;       // head of the 2-entry payload buffer
    logic [7:0]  buf1_q, buf1_d;
    logic [1:0]  buf_cnt_q, buf_cnt_d;
    logic        inflight_q, inflight_d;
    logic [7:0]  req_q, req_d;         // bytes popped from FIFO this packet
    logic [7:0]  sent_q, sent_d;       // payload bytes accepted this packet
    logic [7:0]  csum_q, csum_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    logic        pop_now;
    logic [2:0]  occ;

    assign pkt_cnt = pkt_cnt_q;

    // Output decode and FIFO read request
    always_comb begin
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = 8'h00;
        case (state_q)
            ST_HDR: begin
                m_valid = 1'b1;
                m_data  = HDR_BYTE;
            end
            ST_PAYLOAD: begin
                m_valid = (buf_cnt_q != 2'd0);
                m_data  = buf0_q;
            end
            ST_CSUM: begin
                m_valid = 1'b1;
                m_last  = 1'b1;
                m_data  = csum_q;
            end
            default: ;
        endcase

        pop_now = (state_q == ST_PAYLOAD) && (buf_cnt_q != 2'd0) && m_ready;

        // Buffer occupancy once the in-flight byte lands and any pop is taken;
        // pop_now implies buf_cnt_q >= 1, so this never underflows.
        occ = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_now};

        rd_en = (state_q == ST_PAYLOAD) && !fifo_empty_rd &&
                (req_q < LEN) && (occ < 3'd2);
    end

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        buf_cnt_d  = buf_cnt_q;
        inflight_d = rd_en;
        req_d      = req_q + {7'd0, rd_en};
        sent_d     = sent_q;
        csum_d     = csum_q;
        pkt_cnt_d  = pkt_cnt_q;

        // Pop shifts the buffer first, then a returning FIFO byte is written
        // behind whatever remains, so pop+capture keeps order and count.
        if (pop_now) begin
            buf0_d    = buf1_q;
            buf_cnt_d = buf_cnt_q - 2'd1;
        end
        if (inflight_q) begin
            if (buf_cnt_d == 2'd0) begin
                buf0_d = rd_data;
            end else begin
                buf1_d = rd_data;
            end
            buf_cnt_d = buf_cnt_d + 2'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_rd) begin
                    state_d = ST_HDR;
                    req_d   = 8'd0;
                    sent_d  = 8'd0;
                    csum_d  = 8'd0;
                end
            end
            ST_HDR: begin
                if (m_ready) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (pop_now) begin
                    csum_d = csum_q + buf0_q;
                    sent_d = sent_q + 8'd1;
                    if (sent_q == LEN_M1) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (m_ready) begin
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    if (!fifo_empty_rd) begin
                        state_d = ST_HDR;
                        req_d   = 8'd0;
                        sent_d  = 8'd0;
                        csum_d  = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_rd or negedge rst_rd_n) begin
        if (!rst_rd_n) begin
            state_q    <= ST_IDLE;
            buf0_q     <= 8'h00;
            buf1_q     <= 8'h00;
            buf_cnt_q  <= 2'd0;
            inflight_q <= 1'b0;
            req_q      <= 8'd0;
            sent_q     <= 8'd0;
            csum_q     <= 8'd0;
            pkt_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            buf_cnt_q  <= buf_cnt_d;
            inflight_q <= inflight_d;
            req_q      <= req_d;
            sent_q     <= sent_d;
            csum_q     <= csum_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

endmodule
